// File: rtl/matrix_fetch_issue.sv
// rtl/matrix_fetch_issue.sv - fetches 5x5 int8 operands from byte RAM, packs them for the ALU and issues the opcode
module matrix_fetch_issue #(
  parameter int ADDR_W  = 9,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        opcode_in,
  input  logic [7:0]        escalar_in,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [199:0]      matrizA,
  output logic [199:0]      matrizB,
  output logic [3:0]        alu_opcode,
  output logic [7:0]        alu_escalar,
  input  logic              alu_done,
  output logic              busy,
  output logic              result_valid,
  output logic              error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam int EW = $clog2(TIMEOUT + 1);

  logic [2:0]        state;
  logic [3:0]        op_r;
  logic              binary_r;
  logic [ADDR_W-1:0] base_a_r;
  logic [ADDR_W-1:0] base_b_r;
  logic              sel;
  logic [4:0]        k;
  logic [2:0]        drain_cnt;
  logic [EW-1:0]     exec_cnt;
  logic              error_r;

  // Read tag pipeline: valid, matrix select and element index travel with each read
  logic [RD_LAT-1:0]      pv;
  logic [RD_LAT-1:0]      ps;
  logic [RD_LAT-1:0][4:0] pk;

  logic legal;
  logic is_binary;
  logic accept;

  assign legal     = (opcode_in >= 4'd3) && (opcode_in <= 4'd12);
  assign is_binary = (opcode_in == 4'd3) || (opcode_in == 4'd4) || (opcode_in == 4'd5);
  assign accept    = (state == S_IDLE) && start && legal;

  assign mem_rd_en    = (state == S_READ);
  assign mem_addr     = mem_rd_en ? ((sel ? base_b_r : base_a_r) + ADDR_W'(k)) : '0;
  assign alu_opcode   = (state == S_EXEC) ? op_r : 4'd0;
  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_DONE);
  assign error        = error_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_r        <= '0;
      alu_escalar <= '0;
      binary_r    <= 1'b0;
      base_a_r    <= '0;
      base_b_r    <= '0;
      sel         <= 1'b0;
      k           <= '0;
      drain_cnt   <= '0;
      exec_cnt    <= '0;
      error_r     <= 1'b0;
    end else begin
      error_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (legal) begin
              op_r        <= opcode_in;
              alu_escalar <= escalar_in;
              binary_r    <= is_binary;
              base_a_r    <= base_a;
              base_b_r    <= base_b;
              sel         <= 1'b0;
              k           <= '0;
              state       <= S_READ;
            end else begin
              error_r <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (k == 5'd24) begin
            k <= '0;
            if (!sel && binary_r) begin
              sel <= 1'b1;
            end else begin
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end
          end else begin
            k <= k + 5'd1;
          end
        end
        S_DRAIN: begin
          // Last drain cycle is the one in which the final tag is captured
          if (drain_cnt == 3'(RD_LAT - 1)) begin
            exec_cnt <= '0;
            state    <= S_EXEC;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        S_EXEC: begin
          // alu_done may still reflect the previous operation in the first EXEC cycle
          if ((exec_cnt != '0) && alu_done) begin
            state <= S_DONE;
          end else if (exec_cnt == EW'(TIMEOUT - 1)) begin
            error_r <= 1'b1;
            state   <= S_IDLE;
          end else begin
            exec_cnt <= exec_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pv      <= '0;
      ps      <= '0;
      pk      <= '0;
      matrizA <= '0;
      matrizB <= '0;
    end else begin
      pv[0] <= mem_rd_en;
      ps[0] <= sel;
      pk[0] <= k;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        ps[i] <= ps[i-1];
        pk[i] <= pk[i-1];
      end
      if (accept) begin
        matrizA <= '0;
        matrizB <= '0;
      end
      if (pv[RD_LAT-1]) begin
        if (ps[RD_LAT-1]) begin
          matrizB[{pk[RD_LAT-1], 3'b000} +: 8] <= mem_rdata;
        end else begin
          matrizA[{pk[RD_LAT-1], 3'b000} +: 8] <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_fetch_issue.sv
// tb/tb_matrix_fetch_issue.sv - scoreboard bench for matrix_fetch_issue
module tb_matrix_fetch_issue;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   opcode_in = '0;
  logic [7:0]   escalar_in = '0;
  logic [8:0]   base_a = '0;
  logic [8:0]   base_b = '0;
  logic         mem_rd_en;
  logic [8:0]   mem_addr;
  logic [7:0]   mem_rdata;
  logic [199:0] matrizA;
  logic [199:0] matrizB;
  logic [3:0]   alu_opcode;
  logic [7:0]   alu_escalar;
  logic         alu_done;
  logic         busy;
  logic         result_valid;
  logic         error;

  matrix_fetch_issue #(.ADDR_W(9), .RD_LAT(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode_in(opcode_in),
    .escalar_in(escalar_in), .base_a(base_a), .base_b(base_b),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .matrizA(matrizA), .matrizB(matrizB), .alu_opcode(alu_opcode),
    .alu_escalar(alu_escalar), .alu_done(alu_done), .busy(busy),
    .result_valid(result_valid), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         is_err;
    logic [199:0] a;
    logic [199:0] b;
  } ev_t;

  ev_t        exp_q[$];
  logic [8:0] addr_q[$];
  int         checks = 0;
  int         failures = 0;

  // Byte RAM with two-cycle read latency
  logic [7:0] mem [512];
  logic [8:0] a1 = '0;
  logic [8:0] a2 = '0;
  always @(posedge clk) begin
    a1 <= mem_addr;
    a2 <= a1;
  end
  assign mem_rdata = mem[a2];

  // ALU model: mode 0 raises done in the 4th EXEC cycle, 1 ties high, 2 ties low
  int alu_mode = 0;
  int ecnt = 0;
  always @(posedge clk) ecnt <= (alu_opcode != 4'd0) ? ecnt + 1 : 0;
  assign alu_done = (alu_mode == 1) ? 1'b1 : (alu_mode == 2) ? 1'b0 : (ecnt >= 3);

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  logic prev_done = 1'b0;
  always @(negedge clk) begin : monitor
    ev_t        ev;
    logic [8:0] ea;
    if (!reset) begin
      if (mem_rd_en) begin
        chki("read_expected", int'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) begin
          ea = addr_q.pop_front();
          chki("read_addr", int'(mem_addr), int'(ea));
        end
      end
      if (result_valid || error) begin
        chki("event_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          ev = exp_q.pop_front();
          chki("event_kind_error", int'(error), int'(ev.is_err));
          if (!ev.is_err) begin
            chk("matrizA", matrizA, ev.a);
            chk("matrizB", matrizB, ev.b);
            chki("valid_after_alu_done", int'(prev_done), 1);
            chki("done_opcode_zero", int'(alu_opcode), 0);
            chki("done_busy", int'(busy), 1);
          end
        end
      end
    end
    prev_done <= alu_done;
  end

  task automatic expect_reads(input logic [8:0] base, input int n);
    for (int i = 0; i < n; i++) addr_q.push_back(base + 9'(i));
  endtask

  task automatic expect_done(input logic [8:0] ba, input logic [8:0] bb, input logic bin);
    ev_t ev;
    ev.is_err = 1'b0;
    ev.a = '0;
    ev.b = '0;
    for (int i = 0; i < 25; i++) begin
      ev.a[8*i +: 8] = mem[ba + 9'(i)];
      if (bin) ev.b[8*i +: 8] = mem[bb + 9'(i)];
    end
    exp_q.push_back(ev);
  endtask

  task automatic expect_err();
    ev_t ev;
    ev.is_err = 1'b1;
    ev.a = '0;
    ev.b = '0;
    exp_q.push_back(ev);
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] esc, input logic [8:0] ba, input logic [8:0] bb);
    opcode_in = op;
    escalar_in = esc;
    base_a = ba;
    base_b = bb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output int exec_cycles);
    int n;
    n = 0;
    exec_cycles = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (alu_opcode != 4'd0) exec_cycles++;
    end
    chki("idle_within_bound", int'(n < 300), 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic chk_all_zero(input string tag);
    chki({tag, "_rd_en"}, int'(mem_rd_en), 0);
    chki({tag, "_addr"}, int'(mem_addr), 0);
    chki({tag, "_opcode"}, int'(alu_opcode), 0);
    chki({tag, "_escalar"}, int'(alu_escalar), 0);
    chki({tag, "_busy"}, int'(busy), 0);
    chki({tag, "_valid"}, int'(result_valid), 0);
    chki({tag, "_error"}, int'(error), 0);
    chk({tag, "_matrizA"}, matrizA, '0);
    chk({tag, "_matrizB"}, matrizB, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    int reads;
    int ex;
    ev_t ev;

    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 25; i++) begin
      mem[9'h010 + 9'(i)] = 8'(i);
      mem[9'h040 + 9'(i)] = 8'(2 * i);
    end

    repeat (2) begin @(posedge clk); #1; end
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Binary op: A[k]=k, B[k]=2k, EXEC must begin at cycle 53
    ev.is_err = 1'b0;
    ev.a = '0;
    ev.b = '0;
    for (int i = 0; i < 25; i++) begin
      ev.a[8*i +: 8] = 8'(i);
      ev.b[8*i +: 8] = 8'(2 * i);
    end
    exp_q.push_back(ev);
    expect_reads(9'h010, 25);
    expect_reads(9'h040, 25);
    issue(4'h3, 8'h7E, 9'h010, 9'h040);
    n = 1;
    reads = int'(mem_rd_en);
    while (alu_opcode != 4'h3 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (mem_rd_en) reads++;
    end
    chki("exec_start_cycle", n, 53);
    chki("binary_read_count", reads, 50);
    chki("escalar_latched", int'(alu_escalar), 8'h7E);
    wait_idle(ex);

    // Transpose: 25 reads only, matrizB stays zero
    expect_reads(9'h080, 25);
    expect_done(9'h080, 9'h040, 1'b0);
    issue(4'h6, 8'h01, 9'h080, 9'h040);
    wait_idle(ex);

    // Illegal opcode: error pulse next cycle, no RAM access
    expect_err();
    issue(4'hF, 8'h00, 9'h010, 9'h040);
    chki("illegal_busy", int'(busy), 0);
    chki("illegal_error_pulse", int'(error), 1);
    chki("illegal_no_read", int'(mem_rd_en), 0);
    @(posedge clk); #1;
    chki("illegal_error_one_cycle", int'(error), 0);
    chki("illegal_busy_after", int'(busy), 0);
    wait_idle(ex);

    // alu_done tied high: ignored in first EXEC cycle, accepted in second
    alu_mode = 1;
    expect_reads(9'h100, 25);
    expect_done(9'h100, 9'h000, 1'b0);
    issue(4'h7, 8'h22, 9'h100, 9'h000);
    wait_idle(ex);
    chki("tied_done_exec_cycles", ex, 2);

    // alu_done tied low: timeout after 64 EXEC cycles
    alu_mode = 2;
    expect_reads(9'h120, 25);
    expect_err();
    issue(4'hC, 8'h33, 9'h120, 9'h000);
    wait_idle(ex);
    chki("timeout_exec_cycles", ex, 64);
    chki("timeout_busy", int'(busy), 0);
    alu_mode = 0;

    // Address wrap and start while busy
    expect_reads(9'h1FA, 25);
    expect_done(9'h1FA, 9'h000, 1'b0);
    issue(4'h8, 8'h44, 9'h1FA, 9'h000);
    repeat (6) begin @(posedge clk); #1; end
    chki("wrap_addr", int'(mem_addr), 0);
    opcode_in = 4'h3;
    escalar_in = 8'h99;
    base_a = 9'h010;
    base_b = 9'h040;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chki("busy_start_busy", int'(busy), 1);
    chki("busy_start_escalar", int'(alu_escalar), 8'h44);
    wait_idle(ex);

    // Reset during read k=10, then a clean unary load
    expect_reads(9'h010, 10);
    issue(4'h4, 8'h55, 9'h010, 9'h040);
    repeat (10) begin @(posedge clk); #1; end
    chki("pre_reset_addr", int'(mem_addr), 9'h01A);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("midreset");
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("no_stale_matrizA", matrizA, '0);
    chk("no_stale_matrizB", matrizB, '0);
    expect_reads(9'h0C0, 25);
    expect_done(9'h0C0, 9'h000, 1'b0);
    issue(4'h9, 8'h66, 9'h0C0, 9'h000);
    wait_idle(ex);

    chki("addr_queue_drained", addr_q.size(), 0);
    chki("event_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
